// File: rtl/clk_int_div_cfg_req.sv
// Initiator side of the clock-divider reconfiguration handshake: takes register writes,
// holds each request stable until the divider accepts it, and buffers/coalesces extra writes.
module clk_int_div_cfg_req #(
    parameter int DIV_VALUE_WIDTH   = 4,
    parameter int DEFAULT_DIV_VALUE = 0,
    parameter int TIMEOUT_CYCLES    = 64,
    parameter bit OVERWRITE         = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_valid_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    output logic                       cfg_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    output logic                       busy_o,
    output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
    output logic                       drop_o,
    output logic                       timeout_o,
    input  logic                       clr_timeout_i
);

    generate
        if (DEFAULT_DIV_VALUE < 0 || DEFAULT_DIV_VALUE >= (1 << DIV_VALUE_WIDTH)) begin : g_bad_default
            $error("DEFAULT_DIV_VALUE does not fit in DIV_VALUE_WIDTH bits");
        end
    endgenerate

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int TCNT_W     = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES : 0);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [DIV_VALUE_WIDTH-1:0] DIV_RST = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

    // One-hot pair so that corrupted encodings are distinguishable and recover to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        REQ  = 2'b10
    } state_e;

    state_e                     state_q, state_d;
    logic [DIV_VALUE_WIDTH-1:0] active_q, active_d;
    logic                       div_valid_q, div_valid_d;
    logic [DIV_VALUE_WIDTH-1:0] pend_val_q, pend_val_d;
    logic                       pend_vld_q, pend_vld_d;
    logic [DIV_VALUE_WIDTH-1:0] cur_div_q, cur_div_d;
    logic                       busy_q, busy_d;
    logic                       drop_q, drop_d;
    logic                       timeout_q, timeout_d;
    logic [TCNT_W-1:0]          tcnt_q, tcnt_d;
    logic                       load_active;
    logic                       cfg_fire;

    always_comb begin
        cfg_ready_o = 1'b0;
        case (state_q)
            IDLE:    cfg_ready_o = 1'b1;
            REQ:     cfg_ready_o = OVERWRITE ? 1'b1 : !pend_vld_q;
            default: cfg_ready_o = 1'b0;
        endcase
    end

    assign cfg_fire = cfg_valid_i & cfg_ready_o;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        div_valid_d = div_valid_q;
        pend_val_d  = pend_val_q;
        pend_vld_d  = pend_vld_q;
        cur_div_d   = cur_div_q;
        drop_d      = 1'b0;
        load_active = 1'b0;

        case (state_q)
            IDLE: begin
                div_valid_d = 1'b0;
                if (cfg_fire) begin
                    active_d    = cfg_div_i;
                    load_active = 1'b1;
                    div_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                div_valid_d = 1'b1;
                if (div_ready_i) begin
                    cur_div_d = active_q;
                    if (cfg_fire) begin
                        // Newest write wins over anything still buffered.
                        active_d    = cfg_div_i;
                        load_active = 1'b1;
                        pend_vld_d  = 1'b0;
                        drop_d      = pend_vld_q;
                    end else if (pend_vld_q) begin
                        active_d    = pend_val_q;
                        load_active = 1'b1;
                        pend_vld_d  = 1'b0;
                    end else begin
                        div_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (cfg_fire) begin
                    pend_val_d = cfg_div_i;
                    pend_vld_d = 1'b1;
                    drop_d     = pend_vld_q;
                end
            end
            default: begin
                state_d     = IDLE;
                div_valid_d = 1'b0;
                pend_vld_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == REQ) | pend_vld_d;
    end

    // The request is never withdrawn on timeout; the flag only reports the stall.
    always_comb begin
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (clr_timeout_i) begin
            timeout_d = 1'b0;
        end
        if (TIMEOUT_EN) begin
            if (load_active) begin
                tcnt_d = '0;
            end else if (state_q == REQ && !div_ready_i && tcnt_q != TCNT_MAX) begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == TCNT_LAST) begin
                    timeout_d = 1'b1;
                end
            end
        end else begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            active_q    <= DIV_RST;
            div_valid_q <= 1'b0;
            pend_val_q  <= '0;
            pend_vld_q  <= 1'b0;
            cur_div_q   <= DIV_RST;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            div_valid_q <= div_valid_d;
            pend_val_q  <= pend_val_d;
            pend_vld_q  <= pend_vld_d;
            cur_div_q   <= cur_div_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            timeout_q   <= timeout_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign div_o       = active_q;
    assign div_valid_o = div_valid_q;
    assign cur_div_o   = cur_div_q;
    assign busy_o      = busy_q;
    assign drop_o      = drop_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_clk_int_div_cfg_req.sv
// Bench for clk_int_div_cfg_req: one coalescing instance and one back-pressure instance,
// divider-side acceptances checked against an expected-value queue per instance.
module tb_clk_int_div_cfg_req;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: OVERWRITE=1, TIMEOUT_CYCLES=8
  logic         a_cfg_valid, a_cfg_ready, a_div_valid, a_ready, a_busy, a_drop, a_timeout, a_clr;
  logic [W-1:0] a_cfg_div, a_div, a_cur;
  // Instance B: OVERWRITE=0, TIMEOUT_CYCLES=8
  logic         b_cfg_valid, b_cfg_ready, b_div_valid, b_ready, b_busy, b_drop, b_timeout, b_clr;
  logic [W-1:0] b_cfg_div, b_div, b_cur;

  clk_int_div_cfg_req #(.DIV_VALUE_WIDTH(W), .DEFAULT_DIV_VALUE(0), .TIMEOUT_CYCLES(8), .OVERWRITE(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(a_cfg_valid), .cfg_div_i(a_cfg_div), .cfg_ready_o(a_cfg_ready),
    .div_o(a_div), .div_valid_o(a_div_valid), .div_ready_i(a_ready),
    .busy_o(a_busy), .cur_div_o(a_cur), .drop_o(a_drop),
    .timeout_o(a_timeout), .clr_timeout_i(a_clr)
  );

  clk_int_div_cfg_req #(.DIV_VALUE_WIDTH(W), .DEFAULT_DIV_VALUE(0), .TIMEOUT_CYCLES(8), .OVERWRITE(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(b_cfg_valid), .cfg_div_i(b_cfg_div), .cfg_ready_o(b_cfg_ready),
    .div_o(b_div), .div_valid_o(b_div_valid), .div_ready_i(b_ready),
    .busy_o(b_busy), .cur_div_o(b_cur), .drop_o(b_drop),
    .timeout_o(b_timeout), .clr_timeout_i(b_clr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: every divider-side acceptance pops one expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_div_valid && a_ready) begin
        if (exp_a.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_accept: unexpected acceptance of %0h", a_div);
        end else begin
          chk("a_accept", 32'(a_div), 32'(exp_a.pop_front()));
        end
      end
      if (b_div_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_accept: unexpected acceptance of %0h", b_div);
        end else begin
          chk("b_accept", 32'(b_div), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_cfg_valid = 1'b0; a_cfg_div = '0; a_ready = 1'b0; a_clr = 1'b0;
    b_cfg_valid = 1'b0; b_cfg_div = '0; b_ready = 1'b0; b_clr = 1'b0;
    ticks(3);
    chk("rst_div", 32'(a_div), 32'd0);
    chk("rst_cur", 32'(a_cur), 32'd0);
    chk("rst_valid", 32'(a_div_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_drop", 32'(a_drop), 32'd0);
    chk("rst_timeout", 32'(a_timeout), 32'd0);
    chk("rst_cfg_ready", 32'(a_cfg_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single write of 6, accepted after three cycles
    a_cfg_valid = 1'b1; a_cfg_div = 4'd6; exp_a.push_back(4'd6);
    tick();
    a_cfg_valid = 1'b0;
    chk("t1_valid", 32'(a_div_valid), 32'd1);
    chk("t1_div", 32'(a_div), 32'd6);
    chk("t1_busy", 32'(a_busy), 32'd1);
    ticks(2);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("t1_cur", 32'(a_cur), 32'd6);
    chk("t1_valid_low", 32'(a_div_valid), 32'd0);
    chk("t1_busy_low", 32'(a_busy), 32'd0);

    // Stalled divider, 5 then 7 coalesce; 7 follows 6 with no valid gap
    a_cfg_valid = 1'b1; a_cfg_div = 4'd6; exp_a.push_back(4'd6);
    tick();
    a_cfg_div = 4'd5;
    tick();
    chk("t2_drop_first", 32'(a_drop), 32'd0);
    chk("t2_hold_a", 32'(a_div), 32'd6);
    a_cfg_div = 4'd7;
    tick();
    a_cfg_valid = 1'b0;
    chk("t2_drop", 32'(a_drop), 32'd1);
    chk("t2_hold_b", 32'(a_div), 32'd6);
    tick();
    chk("t2_drop_pulse", 32'(a_drop), 32'd0);
    exp_a.push_back(4'd7);
    a_ready = 1'b1;
    tick();
    chk("t2_cur6", 32'(a_cur), 32'd6);
    chk("t2_div7", 32'(a_div), 32'd7);
    chk("t2_no_gap", 32'(a_div_valid), 32'd1);
    tick();
    a_ready = 1'b0;
    chk("t2_cur7", 32'(a_cur), 32'd7);
    chk("t2_idle", 32'(a_div_valid), 32'd0);

    // Acceptance and new write of 3 in the same cycle with 5 pending
    a_cfg_valid = 1'b1; a_cfg_div = 4'd9; exp_a.push_back(4'd9);
    tick();
    a_cfg_div = 4'd5;
    tick();
    a_cfg_div = 4'd3; a_ready = 1'b1; exp_a.push_back(4'd3);
    tick();
    a_cfg_valid = 1'b0;
    chk("t4_cur", 32'(a_cur), 32'd9);
    chk("t4_div", 32'(a_div), 32'd3);
    chk("t4_drop", 32'(a_drop), 32'd1);
    chk("t4_busy", 32'(a_busy), 32'd1);
    tick();
    a_ready = 1'b0;
    chk("t4_cur3", 32'(a_cur), 32'd3);
    chk("t4_pend_empty", 32'(a_div_valid), 32'd0);
    chk("t4_busy_low", 32'(a_busy), 32'd0);

    // Timeout after 8 unaccepted REQ cycles, then clear
    a_cfg_valid = 1'b1; a_cfg_div = 4'hC; exp_a.push_back(4'hC);
    tick();
    a_cfg_valid = 1'b0;
    ticks(7);
    chk("t5_no_timeout", 32'(a_timeout), 32'd0);
    tick();
    chk("t5_timeout", 32'(a_timeout), 32'd1);
    chk("t5_still_valid", 32'(a_div_valid), 32'd1);
    ticks(2);
    chk("t5_sticky", 32'(a_timeout), 32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("t5_cleared", 32'(a_timeout), 32'd0);
    tick();
    chk("t5_stays_clear", 32'(a_timeout), 32'd0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("t5_cur", 32'(a_cur), 32'hC);

    // Set and clear in the same cycle: set wins
    a_cfg_valid = 1'b1; a_cfg_div = 4'd2; exp_a.push_back(4'd2);
    tick();
    a_cfg_valid = 1'b0;
    ticks(7);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("t5_set_wins", 32'(a_timeout), 32'd1);

    // Back-pressure instance: pending full holds off the third write
    b_cfg_valid = 1'b1; b_cfg_div = 4'd4; exp_b.push_back(4'd4);
    tick();
    b_cfg_div = 4'd5; exp_b.push_back(4'd5);
    tick();
    b_cfg_div = 4'd6; exp_b.push_back(4'd6);
    chk("t3_ready_low", 32'(b_cfg_ready), 32'd0);
    tick();
    chk("t3_ready_low2", 32'(b_cfg_ready), 32'd0);
    chk("t3_hold", 32'(b_div), 32'd4);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("t3_cur4", 32'(b_cur), 32'd4);
    chk("t3_div5", 32'(b_div), 32'd5);
    chk("t3_ready_high", 32'(b_cfg_ready), 32'd1);
    tick();
    b_cfg_valid = 1'b0;
    chk("t3_no_drop", 32'(b_drop), 32'd0);
    chk("t3_busy", 32'(b_busy), 32'd1);
    b_ready = 1'b1;
    tick();
    chk("t3_cur5", 32'(b_cur), 32'd5);
    chk("t3_div6", 32'(b_div), 32'd6);
    tick();
    b_ready = 1'b0;
    chk("t3_cur6", 32'(b_cur), 32'd6);
    chk("t3_idle", 32'(b_div_valid), 32'd0);

    // Asynchronous reset while A has a request outstanding
    chk("t6_pre_valid", 32'(a_div_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t6_valid", 32'(a_div_valid), 32'd0);
    chk("t6_div", 32'(a_div), 32'd0);
    chk("t6_cur", 32'(a_cur), 32'd0);
    chk("t6_timeout", 32'(a_timeout), 32'd0);
    chk("t6_busy", 32'(a_busy), 32'd0);
    chk("t6_b_cur", 32'(b_cur), 32'd0);
    // The outstanding 2 was never accepted and is abandoned by the reset.
    chk("t6_abandoned", 32'(exp_a.size()), 32'd1);
    exp_a.delete();
    tick();
    rst_n = 1'b1;
    ticks(2);
    chk("end_queue_a", 32'(exp_a.size()), 32'd0);
    chk("end_queue_b", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
